lmmi_cfg_readback: RTL and testbench

//  Fabric-side LMMI initiator: reads back a contiguous range of a hard IP's configuration

---
 rtl/lmmi_cfg_readback.sv | 135 +++++++++++++
 tb/tb_lmmi_cfg_readback.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lmmi_cfg_readback.sv
// LMMI read-back initiator: scans a contiguous range of hard-IP configuration
// registers and streams each (offset, data) pair through a valid/ready port.
module lmmi_cfg_readback #(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int TMO_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_offset,
  input  logic [AW:0]   count,
  output logic          busy,
  output logic          done,
  output logic          timeout_err,
  output logic          lmmi_request,
  output logic          lmmi_wr_rdn,
  output logic [AW-1:0] lmmi_offset,
  output logic [DW-1:0] lmmi_wdata,
  input  logic          lmmi_ready,
  input  logic [DW-1:0] lmmi_rdata,
  input  logic          lmmi_rdata_valid,
  output logic          rb_valid,
  input  logic          rb_ready,
  output logic [AW-1:0] rb_offset,
  output logic [DW-1:0] rb_data
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_OUT, S_FIN} state_t;

  // Last idle WAIT count before the read is abandoned (2**TMO_W-1 idle cycles).
  localparam logic [TMO_W-1:0] C_TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t           r_state;
  logic [AW-1:0]    r_offset;
  logic [AW:0]      r_rem;
  logic [TMO_W-1:0] r_tmo;
  logic             r_hit;
  logic [DW-1:0]    r_rb_data;
  logic             r_rb_valid;
  logic             r_req;
  logic             r_busy;
  logic             r_done;
  logic             r_tmo_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_offset   <= '0;
      r_rem      <= '0;
      r_tmo      <= '0;
      r_hit      <= 1'b0;
      r_rb_data  <= '0;
      r_rb_valid <= 1'b0;
      r_req      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tmo_err  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_offset  <= base_offset;
            r_rem     <= count;
            r_tmo_err <= 1'b0;
            r_busy    <= 1'b1;
            if (count == '0) begin
              r_state <= S_FIN;
            end else begin
              r_state <= S_REQ;
              r_req   <= 1'b1;
            end
          end
        end
        S_REQ: begin
          // A zero-wait target may return data together with ready; keep it.
          if (lmmi_ready) begin
            r_req   <= 1'b0;
            r_tmo   <= '0;
            r_hit   <= lmmi_rdata_valid;
            r_state <= S_WAIT;
            if (lmmi_rdata_valid) r_rb_data <= lmmi_rdata;
          end
        end
        S_WAIT: begin
          if (r_hit || lmmi_rdata_valid) begin
            if (!r_hit) r_rb_data <= lmmi_rdata;
            r_hit      <= 1'b0;
            r_rb_valid <= 1'b1;
            r_state    <= S_OUT;
          end else if (r_tmo == C_TMO_LAST) begin
            r_rb_data  <= '1;
            r_tmo_err  <= 1'b1;
            r_rb_valid <= 1'b1;
            r_state    <= S_OUT;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        S_OUT: begin
          if (rb_ready) begin
            r_rb_valid <= 1'b0;
            r_offset   <= r_offset + AW'(1);
            r_rem      <= r_rem - (AW+1)'(1);
            if (r_rem == (AW+1)'(1)) begin
              r_state <= S_FIN;
            end else begin
              r_state <= S_REQ;
              r_req   <= 1'b1;
            end
          end
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign timeout_err  = r_tmo_err;
  assign lmmi_request = r_req;
  assign lmmi_wr_rdn  = 1'b0;
  assign lmmi_offset  = r_offset;
  assign lmmi_wdata   = '0;
  assign rb_valid     = r_rb_valid;
  assign rb_offset    = r_offset;
  assign rb_data      = r_rb_data;

endmodule

// File: tb/tb_lmmi_cfg_readback.sv
// Directed bench for lmmi_cfg_readback: behavioural LMMI target, word monitor,
// one task per scenario with hand-computed expectations.
module tb_lmmi_cfg_readback;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] base_offset = '0;
  logic [8:0] count = '0;
  logic       busy, done, timeout_err, lmmi_request, lmmi_wr_rdn;
  logic [7:0] lmmi_offset, lmmi_wdata;
  logic       lmmi_ready = 1'b0;
  logic [7:0] lmmi_rdata = '0;
  logic       lmmi_rdata_valid = 1'b0;
  logic       rb_valid;
  logic       rb_ready = 1'b1;
  logic [7:0] rb_offset, rb_data;

  lmmi_cfg_readback #(.AW(8), .DW(8), .TMO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_offset(base_offset), .count(count),
    .busy(busy), .done(done), .timeout_err(timeout_err),
    .lmmi_request(lmmi_request), .lmmi_wr_rdn(lmmi_wr_rdn), .lmmi_offset(lmmi_offset),
    .lmmi_wdata(lmmi_wdata), .lmmi_ready(lmmi_ready), .lmmi_rdata(lmmi_rdata),
    .lmmi_rdata_valid(lmmi_rdata_valid), .rb_valid(rb_valid), .rb_ready(rb_ready),
    .rb_offset(rb_offset), .rb_data(rb_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Target configuration
  int         rdy_dly = 0;
  int         vld_dly = 1;
  bit         mute_en = 1'b0;
  logic [7:0] mute_off = '0;

  // Behavioural LMMI target: ready after rdy_dly waiting cycles, data offset^0xA5
  // vld_dly cycles after acceptance (0 = with ready), never for a muted offset.
  initial begin : target
    bit         acc_q;
    logic [7:0] acc_off;
    int         rcnt, vcnt;
    acc_q = 0; acc_off = '0; rcnt = 0; vcnt = 0;
    forever begin
      @(posedge clk); #1;
      lmmi_rdata_valid = 1'b0;
      if (acc_q) begin
        acc_q = 0;
        if (vld_dly > 0 && !(mute_en && acc_off == mute_off)) vcnt = vld_dly;
      end
      if (vcnt > 0) begin
        vcnt--;
        if (vcnt == 0) begin
          lmmi_rdata_valid = 1'b1;
          lmmi_rdata = acc_off ^ 8'hA5;
        end
      end
      if (lmmi_request && rst_n) begin
        if (rcnt >= rdy_dly) begin
          lmmi_ready = 1'b1;
          acc_q = 1;
          acc_off = lmmi_offset;
          rcnt = 0;
          if (vld_dly == 0 && !(mute_en && acc_off == mute_off)) begin
            lmmi_rdata_valid = 1'b1;
            lmmi_rdata = acc_off ^ 8'hA5;
          end
        end else begin
          lmmi_ready = 1'b0;
          rcnt++;
        end
      end else begin
        lmmi_ready = 1'b0;
        rcnt = 0;
      end
    end
  end

  // Monitor
  logic [7:0] q_off[$];
  logic [7:0] q_dat[$];
  int done_cnt, done_cyc, req_cnt, busy_cyc, stab_err, rbv_seen, t_acc, t_rbv;
  bit t_rbv_set;
  logic p_rbv, p_rbr, p_req, p_rdy;
  logic [7:0] p_rboff, p_rbdat, p_loff;
  initial begin
    done_cnt = 0; done_cyc = 0; req_cnt = 0; busy_cyc = 0; stab_err = 0;
    rbv_seen = 0; t_acc = 0; t_rbv = 0; t_rbv_set = 0;
    p_rbv = 0; p_rbr = 0; p_req = 0; p_rdy = 0; p_rboff = '0; p_rbdat = '0; p_loff = '0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      p_rbv = 0; p_req = 0;
    end else begin
      if (rb_valid) rbv_seen++;
      if (rb_valid && rb_ready) begin
        q_off.push_back(rb_offset);
        q_dat.push_back(rb_data);
      end
      if (lmmi_request && lmmi_ready) begin
        req_cnt++;
        if (lmmi_offset == 8'h21) t_acc = cyc;
      end
      if (rb_valid && rb_offset == 8'h21 && !t_rbv_set) begin
        t_rbv = cyc; t_rbv_set = 1;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (busy) busy_cyc++;
      if (p_rbv && !p_rbr && (!rb_valid || rb_offset != p_rboff || rb_data != p_rbdat)) stab_err++;
      if (p_req && !p_rdy && (!lmmi_request || lmmi_offset != p_loff)) stab_err++;
      p_rbv = rb_valid; p_rbr = rb_ready; p_rboff = rb_offset; p_rbdat = rb_data;
      p_req = lmmi_request; p_rdy = lmmi_ready; p_loff = lmmi_offset;
    end
  end

  int start_cyc = 0;

  task automatic clear_mon();
    q_off.delete(); q_dat.delete();
    done_cnt = 0; req_cnt = 0; busy_cyc = 0; stab_err = 0; rbv_seen = 0; t_rbv_set = 0;
  endtask

  task automatic start_pulse(input logic [7:0] b, input logic [8:0] c);
    @(posedge clk); #1;
    base_offset = b; count = c; start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    bit got;
    got = 0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    n_vec++;
    if (!got) begin n_err++; $display("FAIL %s: done not seen within %0d cycles", nm, budget); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({busy, done, timeout_err, lmmi_request, lmmi_wr_rdn, rb_valid} !== 6'b0) begin
      n_err++; $display("FAIL reset_ctl: got %b want 000000",
        {busy, done, timeout_err, lmmi_request, lmmi_wr_rdn, rb_valid});
    end
    n_vec++;
    if ({lmmi_offset, lmmi_wdata, rb_offset, rb_data} !== 32'h0) begin
      n_err++; $display("FAIL reset_data: got %h want 00000000",
        {lmmi_offset, lmmi_wdata, rb_offset, rb_data});
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({busy, lmmi_request} !== 2'b00) begin
      n_err++; $display("FAIL idle_after_reset: got %b want 00", {busy, lmmi_request});
    end
  endtask

  task automatic test_basic();
    logic [7:0] eo[4];
    logic [7:0] ed[4];
    eo = '{8'h10, 8'h11, 8'h12, 8'h13};
    ed = '{8'hB5, 8'hB4, 8'hB7, 8'hB6};
    rdy_dly = 0; vld_dly = 1; rb_ready = 1'b1; clear_mon();
    start_pulse(8'h10, 9'd4);
    wait_done(100, "basic_done");
    n_vec++;
    if (q_off.size() !== 4) begin n_err++; $display("FAIL basic_count: got %0d want 4", q_off.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < q_off.size()) begin
        n_vec++;
        if ({q_off[i], q_dat[i]} !== {eo[i], ed[i]}) begin
          n_err++; $display("FAIL basic_word%0d: got %h want %h", i, {q_off[i], q_dat[i]}, {eo[i], ed[i]});
        end
      end
    end
    n_vec++;
    if (done_cnt !== 1) begin n_err++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
    n_vec++;
    if (timeout_err !== 1'b0) begin n_err++; $display("FAIL basic_tmo: got %b want 0", timeout_err); end
    n_vec++;
    if (done_cyc - start_cyc !== 14) begin
      n_err++; $display("FAIL basic_latency: got %0d want 14", done_cyc - start_cyc);
    end
  endtask

  task automatic test_zero_wait();
    logic [7:0] eo[3];
    logic [7:0] ed[3];
    eo = '{8'h40, 8'h41, 8'h42};
    ed = '{8'hE5, 8'hE4, 8'hE7};
    rdy_dly = 0; vld_dly = 0; rb_ready = 1'b1; clear_mon();
    start_pulse(8'h40, 9'd3);
    wait_done(100, "zw_done");
    n_vec++;
    if (q_off.size() !== 3) begin n_err++; $display("FAIL zw_count: got %0d want 3", q_off.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < q_off.size()) begin
        n_vec++;
        if ({q_off[i], q_dat[i]} !== {eo[i], ed[i]}) begin
          n_err++; $display("FAIL zw_word%0d: got %h want %h", i, {q_off[i], q_dat[i]}, {eo[i], ed[i]});
        end
      end
    end
    n_vec++;
    if (done_cyc - start_cyc !== 11) begin
      n_err++; $display("FAIL zw_throughput: got %0d want 11", done_cyc - start_cyc);
    end
  endtask

  task automatic test_count_zero();
    rdy_dly = 0; vld_dly = 1; clear_mon();
    start_pulse(8'h33, 9'd0);
    wait_done(20, "cz_done");
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (req_cnt !== 0) begin n_err++; $display("FAIL cz_requests: got %0d want 0", req_cnt); end
    n_vec++;
    if (busy_cyc !== 1) begin n_err++; $display("FAIL cz_busy_cycles: got %0d want 1", busy_cyc); end
    n_vec++;
    if (done_cyc - start_cyc !== 2) begin
      n_err++; $display("FAIL cz_done_delay: got %0d want 2", done_cyc - start_cyc);
    end
    n_vec++;
    if (done_cnt !== 1) begin n_err++; $display("FAIL cz_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_wrap();
    logic [7:0] eo[3];
    logic [7:0] ed[3];
    eo = '{8'hFE, 8'hFF, 8'h00};
    ed = '{8'h5B, 8'h5A, 8'hA5};
    rdy_dly = 0; vld_dly = 1; clear_mon();
    start_pulse(8'hFE, 9'd3);
    wait_done(100, "wrap_done");
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (q_off.size() !== 3) begin n_err++; $display("FAIL wrap_count: got %0d want 3", q_off.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < q_off.size()) begin
        n_vec++;
        if ({q_off[i], q_dat[i]} !== {eo[i], ed[i]}) begin
          n_err++; $display("FAIL wrap_word%0d: got %h want %h", i, {q_off[i], q_dat[i]}, {eo[i], ed[i]});
        end
      end
    end
    n_vec++;
    if (req_cnt !== 3) begin n_err++; $display("FAIL wrap_requests: got %0d want 3", req_cnt); end
  endtask

  task automatic test_timeout();
    logic [7:0] eo[3];
    logic [7:0] ed[3];
    eo = '{8'h20, 8'h21, 8'h22};
    ed = '{8'h85, 8'hFF, 8'h87};
    rdy_dly = 0; vld_dly = 1; mute_en = 1'b1; mute_off = 8'h21; clear_mon();
    start_pulse(8'h20, 9'd3);
    wait_done(1000, "tmo_done");
    mute_en = 1'b0;
    n_vec++;
    if (q_off.size() !== 3) begin n_err++; $display("FAIL tmo_count: got %0d want 3", q_off.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < q_off.size()) begin
        n_vec++;
        if ({q_off[i], q_dat[i]} !== {eo[i], ed[i]}) begin
          n_err++; $display("FAIL tmo_word%0d: got %h want %h", i, {q_off[i], q_dat[i]}, {eo[i], ed[i]});
        end
      end
    end
    n_vec++;
    if (t_rbv - t_acc !== 256) begin
      n_err++; $display("FAIL tmo_latency: got %0d want 256", t_rbv - t_acc);
    end
    n_vec++;
    if (timeout_err !== 1'b1) begin n_err++; $display("FAIL tmo_sticky: got %b want 1", timeout_err); end
    n_vec++;
    if (done_cnt !== 1) begin n_err++; $display("FAIL tmo_done_cnt: got %0d want 1", done_cnt); end
    clear_mon();
    start_pulse(8'h30, 9'd1);
    n_vec++;
    if (timeout_err !== 1'b0) begin n_err++; $display("FAIL tmo_clear: got %b want 0", timeout_err); end
    wait_done(100, "tmo_clear_done");
    n_vec++;
    if (q_off.size() !== 1 || {q_off[0], q_dat[0]} !== 16'h3095) begin
      n_err++; $display("FAIL tmo_next_word: got %0d words want one 3095", q_off.size());
    end
  endtask

  task automatic test_stall();
    logic [7:0] eo[3];
    logic [7:0] ed[3];
    bit got;
    eo = '{8'h50, 8'h51, 8'h52};
    ed = '{8'hF5, 8'hF4, 8'hF7};
    rdy_dly = 3; vld_dly = 2; rb_ready = 1'b0; clear_mon();
    start_pulse(8'h50, 9'd3);
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (rb_valid) got = 1;
    end
    n_vec++;
    if (!got) begin n_err++; $display("FAIL stall_first_valid: rb_valid not seen within 50 cycles"); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 4) begin base_offset = 8'h99; count = 9'd1; start = 1'b1; end
      if (i == 5) start = 1'b0;
    end
    @(negedge clk);
    n_vec++;
    if ({rb_valid, rb_offset, rb_data} !== {1'b1, 8'h50, 8'hF5}) begin
      n_err++; $display("FAIL stall_hold: got %h want 150f5", {rb_valid, rb_offset, rb_data});
    end
    @(posedge clk); #1;
    rb_ready = 1'b1;
    wait_done(200, "stall_done");
    repeat (20) @(posedge clk);
    #1;
    n_vec++;
    if (q_off.size() !== 3) begin n_err++; $display("FAIL stall_count: got %0d want 3", q_off.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < q_off.size()) begin
        n_vec++;
        if ({q_off[i], q_dat[i]} !== {eo[i], ed[i]}) begin
          n_err++; $display("FAIL stall_word%0d: got %h want %h", i, {q_off[i], q_dat[i]}, {eo[i], ed[i]});
        end
      end
    end
    n_vec++;
    if (stab_err !== 0) begin n_err++; $display("FAIL stall_stability: got %0d glitches want 0", stab_err); end
    n_vec++;
    if (done_cnt !== 1) begin n_err++; $display("FAIL stall_done_cnt: got %0d want 1", done_cnt); end
    n_vec++;
    if (req_cnt !== 3) begin n_err++; $display("FAIL stall_requests: got %0d want 3", req_cnt); end
    rdy_dly = 0; vld_dly = 1;
  endtask

  task automatic test_reset_mid();
    bit got;
    rdy_dly = 0; vld_dly = 6; rb_ready = 1'b1; clear_mon();
    start_pulse(8'h60, 9'd4);
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (lmmi_request && lmmi_ready) got = 1;
    end
    n_vec++;
    if (!got) begin n_err++; $display("FAIL rst_accept: request not accepted within 20 cycles"); end
    @(negedge clk); #1;
    n_vec++;
    if ({busy, lmmi_offset} !== {1'b1, 8'h60}) begin
      n_err++; $display("FAIL rst_pre_state: got %h want 160", {busy, lmmi_offset});
    end
    rbv_seen = 0;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, timeout_err, lmmi_request, rb_valid, lmmi_offset, rb_offset, rb_data} !== 29'h0) begin
      n_err++; $display("FAIL rst_async: got %h want 0",
        {busy, done, timeout_err, lmmi_request, rb_valid, lmmi_offset, rb_offset, rb_data});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    n_vec++;
    if (rbv_seen !== 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rst_stale: rb_valid cycles %0d busy %b want 0 0", rbv_seen, busy);
    end
    vld_dly = 1; clear_mon();
    start_pulse(8'h70, 9'd2);
    wait_done(100, "rst_fresh_done");
    n_vec++;
    if (q_off.size() !== 2 || {q_off[0], q_dat[0], q_off[1], q_dat[1]} !== 32'h70D571D4) begin
      n_err++; $display("FAIL rst_fresh_words: got %0d words want 70d5,71d4", q_off.size());
    end
    n_vec++;
    if (done_cyc - start_cyc !== 8) begin
      n_err++; $display("FAIL rst_fresh_latency: got %0d want 8", done_cyc - start_cyc);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_zero_wait();
    test_count_zero();
    test_wrap();
    test_timeout();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
